// File: rtl/riscv_pkg.sv
// Shared load/store types and decode helpers for the LSU.
package riscv_pkg;

  // Decoded memory operation handed over from the decoder.
  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LB   = 4'd1,
    LSU_LH   = 4'd2,
    LSU_LW   = 4'd3,
    LSU_LD   = 4'd4,
    LSU_LBU  = 4'd5,
    LSU_LHU  = 4'd6,
    LSU_LWU  = 4'd7,
    LSU_SB   = 4'd8,
    LSU_SH   = 4'd9,
    LSU_SW   = 4'd10,
    LSU_SD   = 4'd11
  } lsu_op_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_t;

  localparam int unsigned LSU_LANES = 8;

  function automatic logic lsu_is_load(input lsu_op_t op);
    logic ld;
    case (op)
      LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU: ld = 1'b1;
      default:                                                  ld = 1'b0;
    endcase
    return ld;
  endfunction

  // log2 of the access size in bytes: 0=B, 1=H, 2=W, 3=D.
  function automatic logic [1:0] lsu_size(input lsu_op_t op);
    logic [1:0] sz;
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: sz = 2'd0;
      LSU_LH, LSU_LHU, LSU_SH: sz = 2'd1;
      LSU_LW, LSU_LWU, LSU_SW: sz = 2'd2;
      default:                 sz = 2'd3;
    endcase
    return sz;
  endfunction

  // An access is misaligned when any offset bit below its size is set.
  function automatic logic lsu_misaligned(input lsu_op_t op, input logic [2:0] off);
    logic mis;
    case (lsu_size(op))
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      2'd2:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store enables/data placement and load
// extraction with sign or zero extension. Purely combinational.
module lsu_align
  import riscv_pkg::*;
(
  input  lsu_op_t     i_op,
  input  logic [2:0]  i_off,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_be,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);

  logic [5:0]  w_shamt;
  logic [7:0]  w_be_base;
  logic [63:0] w_rshift;

  assign w_shamt  = {i_off, 3'b000};
  assign o_wdata  = i_wdata << w_shamt;
  assign w_rshift = i_rdata >> w_shamt;
  assign o_be     = w_be_base << i_off;

  // Unshifted byte-enable pattern for the access size.
  always_comb begin
    w_be_base = 8'hFF;
    case (lsu_size(i_op))
      2'd0:    w_be_base = 8'h01;
      2'd1:    w_be_base = 8'h03;
      2'd2:    w_be_base = 8'h0F;
      default: w_be_base = 8'hFF;
    endcase
  end

  // Truncate the lane-shifted read data and extend it to 64 bits.
  always_comb begin
    o_rdata = w_rshift;
    case (i_op)
      LSU_LB:  o_rdata = {{56{w_rshift[7]}}, w_rshift[7:0]};
      LSU_LBU: o_rdata = {56'd0, w_rshift[7:0]};
      LSU_LH:  o_rdata = {{48{w_rshift[15]}}, w_rshift[15:0]};
      LSU_LHU: o_rdata = {48'd0, w_rshift[15:0]};
      LSU_LW:  o_rdata = {{32{w_rshift[31]}}, w_rshift[31:0]};
      LSU_LWU: o_rdata = {32'd0, w_rshift[31:0]};
      default: o_rdata = w_rshift;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding data-memory master. Accepts one decoded
// access at a time, traps misaligned addresses locally and returns a
// registered completion (with extended load data) to writeback.
module lsu
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  lsu_op_t           lsu_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        rd_addr_i,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [7:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              done_o,
  output logic              wb_we_o,
  output logic [4:0]        wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  lsu_state_t        r_state;
  lsu_op_t           r_op;
  logic [2:0]        r_off;
  logic [4:0]        r_rd;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic              r_done;
  logic              r_wb_we;
  logic [4:0]        r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_err;
  logic [ADDR_W-1:0] r_err_addr;

  lsu_op_t           w_op;
  logic [2:0]        w_off;
  logic [7:0]        w_be;
  logic [63:0]       w_wdata;
  logic [63:0]       w_load;
  logic              w_accept;
  logic              w_misaligned;

  // The aligner is shared: in IDLE it shapes the incoming store, otherwise
  // it extracts load data using the latched op and offset.
  assign w_op  = (r_state == LSU_IDLE) ? lsu_op_i : r_op;
  assign w_off = (r_state == LSU_IDLE) ? addr_i[2:0] : r_off;

  lsu_align u_align (
    .i_op    (w_op),
    .i_off   (w_off),
    .i_wdata (wdata_i),
    .i_rdata (dmem_rdata_i),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_load)
  );

  assign w_accept     = (r_state == LSU_IDLE) && valid_i && (lsu_op_i != LSU_NONE);
  assign w_misaligned = lsu_misaligned(lsu_op_i, addr_i[2:0]);

  // Request/response FSM with registered bus and writeback outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= LSU_IDLE;
      r_op       <= LSU_NONE;
      r_off      <= '0;
      r_rd       <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_done  <= 1'b0;
      r_wb_we <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (w_accept) begin
            if (w_misaligned) begin
              r_err      <= 1'b1;
              r_err_addr <= addr_i;
            end else begin
              r_op    <= lsu_op_i;
              r_off   <= addr_i[2:0];
              r_rd    <= rd_addr_i;
              r_we    <= ~lsu_is_load(lsu_op_i);
              r_addr  <= {addr_i[ADDR_W-1:3], 3'b000};
              r_be    <= w_be;
              r_wdata <= w_wdata;
              r_state <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (dmem_gnt_i) r_state <= LSU_WAIT;
        end
        LSU_WAIT: begin
          if (dmem_rvalid_i) begin
            r_done    <= 1'b1;
            r_wb_we   <= lsu_is_load(r_op);
            r_wb_rd   <= r_rd;
            r_wb_data <= lsu_is_load(r_op) ? w_load : '0;
            r_state   <= LSU_IDLE;
          end
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign ready_o      = (r_state == LSU_IDLE);
  // Gated by reset so an in-flight request is withdrawn in the reset cycle.
  assign dmem_req_o   = (r_state == LSU_REQ) && !rst_i;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;
  assign done_o       = r_done;
  assign wb_we_o      = r_wb_we;
  assign wb_rd_o      = r_wb_rd;
  assign wb_data_o    = r_wb_data;
  assign err_o        = r_err;
  assign err_addr_o   = r_err_addr;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for the load/store unit.
module tb_lsu;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready_o;
  lsu_op_t     lsu_op;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [4:0]  rd_addr;
  logic        dmem_req_o;
  logic        gnt;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [7:0]  dmem_be_o;
  logic [63:0] dmem_wdata_o;
  logic        rvalid;
  logic [63:0] rdata;
  logic        done_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_data_o;
  logic        err_o;
  logic [63:0] err_addr_o;

  int checks = 0;
  int errors = 0;

  // Observations collected by run_op.
  logic        obs_acc_ready, obs_req_ok, obs_wait_ok, obs_we, obs_done, obs_wbwe, obs_ready_done;
  logic [63:0] obs_addr, obs_wdata, obs_wbdata;
  logic [7:0]  obs_be;
  logic [4:0]  obs_wbrd;

  lsu #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .valid_i       (valid),
    .ready_o       (ready_o),
    .lsu_op_i      (lsu_op),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .rd_addr_i     (rd_addr),
    .dmem_req_o    (dmem_req_o),
    .dmem_gnt_i    (gnt),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_rvalid_i (rvalid),
    .dmem_rdata_i  (rdata),
    .done_o        (done_o),
    .wb_we_o       (wb_we_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .err_o         (err_o),
    .err_addr_o    (err_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (byte-level view of the rules) --------
  function automatic int op_bytes(input lsu_op_t op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: return 1;
      LSU_LH, LSU_LHU, LSU_SH: return 2;
      LSU_LW, LSU_LWU, LSU_SW: return 4;
      default:                 return 8;
    endcase
  endfunction

  function automatic bit op_load(input lsu_op_t op);
    return op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU};
  endfunction

  function automatic bit op_signed(input lsu_op_t op);
    return op inside {LSU_LB, LSU_LH, LSU_LW};
  endfunction

  function automatic bit ref_misaligned(input lsu_op_t op, input logic [63:0] a);
    int off = int'(a[2:0]);
    return (off % op_bytes(op)) != 0;
  endfunction

  function automatic logic [7:0] ref_be(input lsu_op_t op, input logic [63:0] a);
    logic [7:0] b = '0;
    int off = int'(a[2:0]);
    for (int i = 0; i < op_bytes(op); i++) b[off + i] = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] a, input logic [63:0] wd);
    logic [63:0] w = '0;
    int off = int'(a[2:0]);
    for (int j = off; j < 8; j++) w[8*j +: 8] = wd[8*(j - off) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] ref_load(input lsu_op_t op, input logic [63:0] a,
                                           input logic [63:0] rd);
    logic [63:0] v = '0;
    int off = int'(a[2:0]);
    int n = op_bytes(op);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off + i) +: 8];
    if (op_signed(op) && v[8*n - 1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- driver: one full aligned access --------------------
  // Called at posedge+1; presents the request, holds gnt low for gnt_wait
  // REQ cycles (with stray rvalid), grants, then answers with rvalid.
  task automatic run_op(input lsu_op_t op, input logic [63:0] a, input logic [63:0] wd,
                        input logic [4:0] rd, input logic [63:0] rdat, input int gnt_wait);
    obs_acc_ready = ready_o;
    valid = 1'b1; lsu_op = op; addr = a; wdata = wd; rd_addr = rd;
    @(posedge clk); #1;
    valid = 1'b0; lsu_op = LSU_NONE;
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom}; rd_addr = 5'($urandom);
    obs_we = dmem_we_o; obs_addr = dmem_addr_o; obs_be = dmem_be_o; obs_wdata = dmem_wdata_o;
    obs_req_ok = dmem_req_o && !ready_o && !done_o && !err_o;
    for (int i = 0; i < gnt_wait; i++) begin
      rvalid = 1'b1; rdata = {$urandom, $urandom};
      @(posedge clk); #1;
      if (!(dmem_req_o && !ready_o && !done_o && dmem_we_o === obs_we &&
            dmem_addr_o === obs_addr && dmem_be_o === obs_be && dmem_wdata_o === obs_wdata))
        obs_req_ok = 1'b0;
    end
    rvalid = 1'b0; gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    obs_wait_ok = !dmem_req_o && !ready_o && !done_o;
    rvalid = 1'b1; rdata = rdat;
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = {$urandom, $urandom};
    obs_done = done_o; obs_wbwe = wb_we_o; obs_wbrd = wb_rd_o; obs_wbdata = wb_data_o;
    obs_ready_done = ready_o;
  endtask

  // ---------------- tests --------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", dmem_req_o); end
    checks++;
    if ({done_o, wb_we_o, err_o, dmem_we_o} !== 4'b0 || dmem_be_o !== 8'h00 ||
        wb_data_o !== 64'h0 || err_addr_o !== 64'h0 || dmem_addr_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs got done=%b wbwe=%b err=%b be=%h wbdata=%h exp all zero",
               done_o, wb_we_o, err_o, dmem_be_o, wb_data_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_sd();
    run_op(LSU_SD, 64'h1000, 64'h1122334455667788, 5'd3, 64'h0, 0);
    checks++; if (obs_acc_ready !== 1'b1) begin errors++; $display("FAIL sd_ready got %b exp 1", obs_acc_ready); end
    checks++; if (obs_req_ok !== 1'b1) begin errors++; $display("FAIL sd_req got %b exp 1", obs_req_ok); end
    checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL sd_we got %b exp 1", obs_we); end
    checks++; if (obs_addr !== 64'h1000) begin errors++; $display("FAIL sd_addr got %h exp 1000", obs_addr); end
    checks++; if (obs_be !== 8'hFF) begin errors++; $display("FAIL sd_be got %h exp ff", obs_be); end
    checks++; if (obs_wdata !== 64'h1122334455667788) begin errors++; $display("FAIL sd_wdata got %h exp 1122334455667788", obs_wdata); end
    checks++; if (obs_wait_ok !== 1'b1) begin errors++; $display("FAIL sd_wait got %b exp 1", obs_wait_ok); end
    checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL sd_done_n3 got %b exp 1", obs_done); end
    checks++; if (obs_wbwe !== 1'b0) begin errors++; $display("FAIL sd_wbwe got %b exp 0", obs_wbwe); end
    checks++; if (obs_wbdata !== 64'h0) begin errors++; $display("FAIL sd_wbdata got %h exp 0", obs_wbdata); end
    checks++; if (obs_ready_done !== 1'b1) begin errors++; $display("FAIL sd_ready_done got %b exp 1", obs_ready_done); end
    @(posedge clk); #1;
    checks++; if (done_o !== 1'b0 || wb_we_o !== 1'b0) begin errors++; $display("FAIL sd_done_pulse got %b exp 0", done_o); end
  endtask

  task automatic test_loads();
    lsu_op_t     ops[4]  = '{LSU_LB, LSU_LBU, LSU_LW, LSU_LWU};
    logic [63:0] adr[4]  = '{64'h2003, 64'h2003, 64'h4004, 64'h4004};
    logic [63:0] rdt[4]  = '{64'h0000000080000000, 64'h0000000080000000,
                             64'hDEADBEEF00000000, 64'hDEADBEEF00000000};
    logic [63:0] expd[4] = '{64'hFFFFFFFFFFFFFF80, 64'h0000000000000080,
                             64'hFFFFFFFFDEADBEEF, 64'h00000000DEADBEEF};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], adr[i], 64'h0, 5'(i + 7), rdt[i], 0);
      checks++; if (obs_we !== 1'b0 || obs_addr !== {adr[i][63:3], 3'b000}) begin
        errors++; $display("FAIL load%0d_bus got we=%b addr=%h exp we=0 addr=%h", i, obs_we, obs_addr, {adr[i][63:3], 3'b000}); end
      checks++; if (obs_done !== 1'b1 || obs_wbwe !== 1'b1) begin
        errors++; $display("FAIL load%0d_done got done=%b wbwe=%b exp 1 1", i, obs_done, obs_wbwe); end
      checks++; if (obs_wbrd !== 5'(i + 7)) begin errors++; $display("FAIL load%0d_rd got %0d exp %0d", i, obs_wbrd, i + 7); end
      checks++; if (obs_wbdata !== expd[i]) begin errors++; $display("FAIL load%0d_data got %h exp %h", i, obs_wbdata, expd[i]); end
    end
  endtask

  task automatic test_sh_stall();
    run_op(LSU_SH, 64'h3006, 64'h000000000000ABCD, 5'd1, 64'h0, 3);
    checks++; if (obs_req_ok !== 1'b1) begin errors++; $display("FAIL sh_stall_stable got %b exp 1", obs_req_ok); end
    checks++; if (obs_be !== 8'hC0) begin errors++; $display("FAIL sh_be got %h exp c0", obs_be); end
    checks++; if (obs_wdata[63:48] !== 16'hABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcd", obs_wdata[63:48]); end
    checks++; if (obs_addr !== 64'h3000) begin errors++; $display("FAIL sh_addr got %h exp 3000", obs_addr); end
    checks++; if (obs_done !== 1'b1 || obs_wbwe !== 1'b0) begin errors++; $display("FAIL sh_done got %b%b exp 10", obs_done, obs_wbwe); end
  endtask

  task automatic test_misaligned();
    valid = 1'b1; lsu_op = LSU_LW; addr = 64'h2002;
    @(posedge clk); #1;
    valid = 1'b0; lsu_op = LSU_NONE;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", err_o); end
    checks++; if (err_addr_o !== 64'h2002) begin errors++; $display("FAIL mis_addr got %h exp 2002", err_addr_o); end
    checks++; if (dmem_req_o !== 1'b0 || ready_o !== 1'b1 || done_o !== 1'b0) begin
      errors++; $display("FAIL mis_state got req=%b ready=%b done=%b exp 0 1 0", dmem_req_o, ready_o, done_o); end
    @(posedge clk); #1;
    checks++; if (err_o !== 1'b0 || dmem_req_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL mis_pulse got err=%b req=%b exp 0 0", err_o, dmem_req_o); end
  endtask

  task automatic test_ignored();
    // LSU_NONE and spurious gnt/rvalid while idle do nothing.
    valid = 1'b1; lsu_op = LSU_NONE; addr = 64'h1; gnt = 1'b1; rvalid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    checks++; if (dmem_req_o !== 1'b0 || err_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL none_ignored got req=%b err=%b ready=%b exp 0 0 1", dmem_req_o, err_o, ready_o); end
    @(posedge clk); #1;
    checks++; if (done_o !== 1'b0 || wb_we_o !== 1'b0) begin
      errors++; $display("FAIL spurious_done got %b exp 0", done_o); end
  endtask

  task automatic test_reset_mid();
    // Reset during REQ withdraws the request in that same cycle.
    valid = 1'b1; lsu_op = LSU_SD; addr = 64'h5000; wdata = 64'h1;
    @(posedge clk); #1;
    valid = 1'b0; lsu_op = LSU_NONE;
    rst = 1'b1; #1;
    checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req_drop got %b exp 0", dmem_req_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    // LD reset in WAIT, late rvalid must be ignored.
    valid = 1'b1; lsu_op = LSU_LD; addr = 64'h6000; rd_addr = 5'd9;
    @(posedge clk); #1;
    valid = 1'b0; lsu_op = LSU_NONE; gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rvalid = 1'b1; rdata = 64'hCAFEF00DCAFEF00D;
    checks++; if (ready_o !== 1'b1 || dmem_req_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL rst_wait_state got ready=%b req=%b done=%b exp 1 0 0", ready_o, dmem_req_o, done_o); end
    @(posedge clk); #1;
    rvalid = 1'b0;
    checks++; if (done_o !== 1'b0 || wb_we_o !== 1'b0 || ready_o !== 1'b1 || dmem_req_o !== 1'b0) begin
      errors++; $display("FAIL rst_late_rvalid got done=%b wbwe=%b exp 0 0", done_o, wb_we_o); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      lsu_op_t     op  = lsu_op_t'(4'($urandom_range(1, 11)));
      logic [63:0] a   = {$urandom, $urandom};
      logic [63:0] wd  = {$urandom, $urandom};
      logic [63:0] rdt = {$urandom, $urandom};
      logic [4:0]  rd  = 5'($urandom);
      int          n   = op_bytes(op);
      if ($urandom_range(0, 9) < 7) a = a & ~64'(n - 1);
      if (ref_misaligned(op, a)) begin
        valid = 1'b1; lsu_op = op; addr = a;
        @(posedge clk); #1;
        valid = 1'b0; lsu_op = LSU_NONE;
        checks++; if (err_o !== 1'b1 || err_addr_o !== a || dmem_req_o !== 1'b0) begin
          errors++; $display("FAIL rnd%0d_mis got err=%b addr=%h req=%b exp 1 %h 0", it, err_o, err_addr_o, dmem_req_o, a); end
      end else begin
        run_op(op, a, wd, rd, rdt, int'($urandom_range(0, 2)));
        checks++; if (obs_req_ok !== 1'b1 || obs_wait_ok !== 1'b1 || obs_done !== 1'b1) begin
          errors++; $display("FAIL rnd%0d_handshake got req=%b wait=%b done=%b exp 1 1 1", it, obs_req_ok, obs_wait_ok, obs_done); end
        checks++; if (obs_be !== ref_be(op, a) || obs_addr !== {a[63:3], 3'b000} || obs_we !== !op_load(op)) begin
          errors++; $display("FAIL rnd%0d_bus got be=%h addr=%h we=%b exp %h %h %b", it, obs_be, obs_addr, obs_we, ref_be(op, a), {a[63:3], 3'b000}, !op_load(op)); end
        if (op_load(op)) begin
          checks++; if (obs_wbdata !== ref_load(op, a, rdt) || obs_wbwe !== 1'b1 || obs_wbrd !== rd) begin
            errors++; $display("FAIL rnd%0d_load got %h we=%b rd=%0d exp %h 1 %0d", it, obs_wbdata, obs_wbwe, obs_wbrd, ref_load(op, a, rdt), rd); end
        end else begin
          checks++; if (obs_wdata !== ref_wdata(a, wd) || obs_wbwe !== 1'b0 || obs_wbdata !== 64'h0) begin
            errors++; $display("FAIL rnd%0d_store got %h we=%b exp %h 0", it, obs_wdata, obs_wbwe, ref_wdata(a, wd)); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; lsu_op = LSU_NONE; addr = '0; wdata = '0; rd_addr = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    test_reset();
    test_store_sd();
    test_loads();
    test_sh_stall();
    test_misaligned();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
